// File: rtl/rgmii_pkg.sv
// Shared types for the RGMII link controller: speed codes, FSM states, status tuple.
// No logic, no latency; no flow control.
package rgmii_pkg;

    localparam logic [1:0] SPD_10   = 2'b00;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_RSVD = 2'b11;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        INIT,
        DOWN,
        QUAL,
        SWITCH,
        SETTLE,
        UP
    } state_t;

    typedef struct packed {
        logic       up;
        logic [1:0] spd;
        logic       dplx;
    } link_st_t;

    // Reserved speed is treated as link down.
    function automatic logic valid_up(input link_st_t s);
        return s.up && (s.spd != SPD_RSVD);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for quasi-static async inputs into the clk domain.
// Latency 2 cycles; no backpressure.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rgmii_link_ctrl.sv
// Qualifies in-band/forced link status, sequences receiver reset on speed-class change.
// Latency 2 + 1 + STABLE_CYCLES (+ RESET_CYCLES + SETTLE_CYCLES on switch); no backpressure.
module rgmii_link_ctrl
    import rgmii_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int RESET_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_auto,
    input  logic [1:0]  cfg_speed,
    input  logic        cfg_duplex,
    input  logic        ibs_up,
    input  logic [1:0]  ibs_spd,
    input  logic        ibs_dplx,
    output logic        rx_speed,
    output logic        rx_reset,
    output logic        link_up,
    output logic [1:0]  link_speed,
    output logic        link_duplex,
    output logic        link_chg,
    output logic [15:0] flap_cnt,
    input  logic        flap_clr
);

    localparam logic [CNT_W-1:0] STABLE_LD = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LD  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [3:0] ibs_s;
    link_st_t   eff;
    link_st_t   rep;
    logic       flap_inc;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    link_st_t         cand_q, cand_d;
    logic             rx_speed_q, rx_speed_d;
    logic             rx_reset_q, rx_reset_d;
    logic             link_up_q, link_up_d;
    logic [1:0]       link_speed_q, link_speed_d;
    logic             link_duplex_q, link_duplex_d;
    logic             link_chg_q, link_chg_d;
    logic [15:0]      flap_cnt_q, flap_cnt_d;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({ibs_up, ibs_spd, ibs_dplx}),
        .q     (ibs_s)
    );

    assign eff = cfg_auto ? link_st_t'(ibs_s) : link_st_t'({1'b1, cfg_speed, cfg_duplex});
    assign rep = link_st_t'({link_up_q, link_speed_q, link_duplex_q});

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        rx_speed_d    = rx_speed_q;
        rx_reset_d    = rx_reset_q;
        link_up_d     = link_up_q;
        link_speed_d  = link_speed_q;
        link_duplex_d = link_duplex_q;
        link_chg_d    = 1'b0;
        flap_inc      = 1'b0;

        case (state_q)
            INIT: begin
                if (cnt_q == '0) begin
                    state_d    = DOWN;
                    rx_reset_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DOWN: begin
                if (valid_up(eff)) begin
                    cand_d  = eff;
                    cnt_d   = STABLE_LD;
                    state_d = QUAL;
                end
            end
            UP: begin
                if (eff != rep) begin
                    cand_d  = eff;
                    cnt_d   = STABLE_LD;
                    state_d = QUAL;
                end
            end
            QUAL: begin
                // A glitch that reverts to the reported status aborts qualification silently.
                if (eff == rep) begin
                    state_d = link_up_q ? UP : DOWN;
                end else if (eff != cand_q) begin
                    cand_d = eff;
                    cnt_d  = STABLE_LD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!valid_up(cand_q)) begin
                    state_d = DOWN;
                    if (link_up_q) begin
                        link_up_d  = 1'b0;
                        link_chg_d = 1'b1;
                        flap_inc   = 1'b1;
                    end
                end else if ((cand_q.spd == SPD_1000) != rx_speed_q) begin
                    state_d    = SWITCH;
                    cnt_d      = RESET_LD;
                    rx_reset_d = 1'b1;
                    rx_speed_d = (cand_q.spd == SPD_1000);
                    if (link_up_q) begin
                        link_up_d  = 1'b0;
                        link_chg_d = 1'b1;
                        flap_inc   = 1'b1;
                    end
                end else begin
                    state_d       = UP;
                    link_up_d     = 1'b1;
                    link_speed_d  = cand_q.spd;
                    link_duplex_d = cand_q.dplx;
                    link_chg_d    = 1'b1;
                end
            end
            SWITCH: begin
                if (cnt_q == '0) begin
                    state_d    = SETTLE;
                    rx_reset_d = 1'b0;
                    cnt_d      = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d       = UP;
                    link_up_d     = 1'b1;
                    link_speed_d  = cand_q.spd;
                    link_duplex_d = cand_q.dplx;
                    link_chg_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (flap_clr) begin
            flap_cnt_d = 16'h0000;
        end else if (flap_inc && (flap_cnt_q != 16'hFFFF)) begin
            flap_cnt_d = flap_cnt_q + 16'd1;
        end else begin
            flap_cnt_d = flap_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= INIT;
            cnt_q         <= RESET_LD;
            cand_q        <= link_st_t'({1'b0, SPD_1000, 1'b1});
            rx_speed_q    <= 1'b1;
            rx_reset_q    <= 1'b1;
            link_up_q     <= 1'b0;
            link_speed_q  <= SPD_1000;
            link_duplex_q <= 1'b1;
            link_chg_q    <= 1'b0;
            flap_cnt_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            rx_speed_q    <= rx_speed_d;
            rx_reset_q    <= rx_reset_d;
            link_up_q     <= link_up_d;
            link_speed_q  <= link_speed_d;
            link_duplex_q <= link_duplex_d;
            link_chg_q    <= link_chg_d;
            flap_cnt_q    <= flap_cnt_d;
        end
    end

    assign rx_speed    = rx_speed_q;
    assign rx_reset    = rx_reset_q;
    assign link_up     = link_up_q;
    assign link_speed  = link_speed_q;
    assign link_duplex = link_duplex_q;
    assign link_chg    = link_chg_q;
    assign flap_cnt    = flap_cnt_q;

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Directed bench for rgmii_link_ctrl with STABLE=8, RESET=4, SETTLE=6.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_rgmii_link_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_auto;
    logic [1:0]  cfg_speed;
    logic        cfg_duplex;
    logic        ibs_up;
    logic [1:0]  ibs_spd;
    logic        ibs_dplx;
    logic        rx_speed;
    logic        rx_reset;
    logic        link_up;
    logic [1:0]  link_speed;
    logic        link_duplex;
    logic        link_chg;
    logic [15:0] flap_cnt;
    logic        flap_clr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rgmii_link_ctrl #(
        .STABLE_CYCLES (8),
        .RESET_CYCLES  (4),
        .SETTLE_CYCLES (6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_auto    (cfg_auto),
        .cfg_speed   (cfg_speed),
        .cfg_duplex  (cfg_duplex),
        .ibs_up      (ibs_up),
        .ibs_spd     (ibs_spd),
        .ibs_dplx    (ibs_dplx),
        .rx_speed    (rx_speed),
        .rx_reset    (rx_reset),
        .link_up     (link_up),
        .link_speed  (link_speed),
        .link_duplex (link_duplex),
        .link_chg    (link_chg),
        .flap_cnt    (flap_cnt),
        .flap_clr    (flap_clr)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_auto = 1'b1; cfg_speed = 2'b10; cfg_duplex = 1'b1;
        ibs_up = 1'b1; ibs_spd = 2'b10; ibs_dplx = 1'b1; flap_clr = 1'b0;
        step(2);
        n_tests++;
        if ({rx_speed, rx_reset, link_up, link_speed, link_duplex, link_chg} !== 7'b1101010 || flap_cnt !== 16'h0) begin
            $display("FAIL reset_vals: got spd=%b rst=%b up=%b ls=%b ld=%b chg=%b flap=%h want 1 1 0 10 1 0 0000",
                     rx_speed, rx_reset, link_up, link_speed, link_duplex, link_chg, flap_cnt);
            n_fail++;
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            n_tests++;
            if (rx_reset !== (c <= 3) || rx_speed !== 1'b1) begin
                $display("FAIL init_seq c=%0d: rx_reset=%b rx_speed=%b want %b 1", c, rx_reset, rx_speed, (c <= 3));
                n_fail++;
            end
            if (c == 12) begin
                n_tests++;
                if (link_up !== 1'b0) begin
                    $display("FAIL init_early_up: link_up=%b want 0", link_up);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if ({link_up, link_speed, link_duplex, link_chg} !== 5'b11011) begin
            $display("FAIL init_up: got up=%b spd=%b dplx=%b chg=%b want 1 10 1 1", link_up, link_speed, link_duplex, link_chg);
            n_fail++;
        end
    endtask

    task automatic test_glitch();
        ibs_up = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (c == 5) ibs_up = 1'b1;
            n_tests++;
            if (link_up !== 1'b1 || link_chg !== 1'b0 || link_speed !== 2'b10) begin
                $display("FAIL glitch c=%0d: up=%b chg=%b spd=%b want 1 0 10", c, link_up, link_chg, link_speed);
                n_fail++;
            end
        end
        n_tests++;
        if (flap_cnt !== 16'd0) begin
            $display("FAIL glitch_flap: flap_cnt=%0d want 0", flap_cnt);
            n_fail++;
        end
    endtask

    task automatic test_speed_switch();
        ibs_spd = 2'b01;
        for (int c = 1; c <= 21; c++) begin
            step();
            case (c)
                10: begin
                    n_tests++;
                    if ({link_up, rx_reset, rx_speed} !== 3'b101) begin
                        $display("FAIL sw_pre: up=%b rst=%b spd=%b want 1 0 1", link_up, rx_reset, rx_speed);
                        n_fail++;
                    end
                end
                11: begin
                    n_tests++;
                    if ({link_up, link_chg, rx_reset, rx_speed} !== 4'b0110 || flap_cnt !== 16'd1) begin
                        $display("FAIL sw_entry: up=%b chg=%b rst=%b spd=%b flap=%0d want 0 1 1 0 1",
                                 link_up, link_chg, rx_reset, rx_speed, flap_cnt);
                        n_fail++;
                    end
                end
                14: begin
                    n_tests++;
                    if (rx_reset !== 1'b1 || link_chg !== 1'b0) begin
                        $display("FAIL sw_hold: rst=%b chg=%b want 1 0", rx_reset, link_chg);
                        n_fail++;
                    end
                end
                15: begin
                    n_tests++;
                    if (rx_reset !== 1'b0 || rx_speed !== 1'b0) begin
                        $display("FAIL sw_release: rst=%b spd=%b want 0 0", rx_reset, rx_speed);
                        n_fail++;
                    end
                end
                20: begin
                    n_tests++;
                    if (link_up !== 1'b0) begin
                        $display("FAIL sw_settle: up=%b want 0", link_up);
                        n_fail++;
                    end
                end
                21: begin
                    n_tests++;
                    if ({link_up, link_speed, link_duplex, link_chg} !== 5'b10111) begin
                        $display("FAIL sw_up: up=%b spd=%b dplx=%b chg=%b want 1 01 1 1", link_up, link_speed, link_duplex, link_chg);
                        n_fail++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_reserved();
        ibs_spd = 2'b11;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 10) begin
                n_tests++;
                if (link_up !== 1'b1) begin
                    $display("FAIL rsvd_pre: up=%b want 1", link_up);
                    n_fail++;
                end
            end
            if (c == 11) begin
                n_tests++;
                if (link_up !== 1'b0 || link_chg !== 1'b1 || flap_cnt !== 16'd2) begin
                    $display("FAIL rsvd_down: up=%b chg=%b flap=%0d want 0 1 2", link_up, link_chg, flap_cnt);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (link_up !== 1'b0 || link_chg !== 1'b0) begin
            $display("FAIL rsvd_hold: up=%b chg=%b want 0 0", link_up, link_chg);
            n_fail++;
        end
    endtask

    task automatic test_forced();
        cfg_auto = 1'b0; cfg_speed = 2'b00; cfg_duplex = 1'b0; ibs_up = 1'b0;
        step(8);
        n_tests++;
        if (link_up !== 1'b0) begin
            $display("FAIL forced_pre: up=%b want 0", link_up);
            n_fail++;
        end
        step();
        n_tests++;
        if ({link_up, link_speed, link_duplex, link_chg, rx_speed, rx_reset} !== 7'b1000100) begin
            $display("FAIL forced_up: up=%b spd=%b dplx=%b chg=%b rxs=%b rxr=%b want 1 00 0 1 0 0",
                     link_up, link_speed, link_duplex, link_chg, rx_speed, rx_reset);
            n_fail++;
        end
    endtask

    task automatic test_flap_sat();
        force dut.flap_cnt_q = 16'hFFFF;
        step();
        release dut.flap_cnt_q;
        cfg_speed = 2'b11;
        step(9);
        n_tests++;
        if (link_up !== 1'b0 || link_chg !== 1'b1 || flap_cnt !== 16'hFFFF) begin
            $display("FAIL flap_sat: up=%b chg=%b flap=%h want 0 1 ffff", link_up, link_chg, flap_cnt);
            n_fail++;
        end
        cfg_speed = 2'b00;
        step(9);
        n_tests++;
        if (link_up !== 1'b1) begin
            $display("FAIL flap_reup: up=%b want 1", link_up);
            n_fail++;
        end
        cfg_speed = 2'b11;
        step(8);
        flap_clr = 1'b1;
        step();
        flap_clr = 1'b0;
        n_tests++;
        if (link_up !== 1'b0 || flap_cnt !== 16'h0000) begin
            $display("FAIL flap_clr_wins: up=%b flap=%h want 0 0000", link_up, flap_cnt);
            n_fail++;
        end
    endtask

    task automatic test_reset_in_settle();
        cfg_speed = 2'b10;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 9 || c == 12) begin
                n_tests++;
                if (rx_reset !== 1'b1 || rx_speed !== 1'b1 || link_chg !== 1'b0) begin
                    $display("FAIL settle_sw c=%0d: rst=%b spd=%b chg=%b want 1 1 0", c, rx_reset, rx_speed, link_chg);
                    n_fail++;
                end
            end
            if (c == 15) begin
                n_tests++;
                if (rx_reset !== 1'b0 || link_up !== 1'b0) begin
                    $display("FAIL settle_phase: rst=%b up=%b want 0 0", rx_reset, link_up);
                    n_fail++;
                end
            end
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rx_speed, rx_reset, link_up, link_speed, link_duplex, link_chg} !== 7'b1101010 || flap_cnt !== 16'h0) begin
            $display("FAIL midrst_vals: got spd=%b rst=%b up=%b ls=%b ld=%b chg=%b flap=%h want 1 1 0 10 1 0 0000",
                     rx_speed, rx_reset, link_up, link_speed, link_duplex, link_chg, flap_cnt);
            n_fail++;
        end
        rst_n = 1'b1;
        step(3);
        n_tests++;
        if (rx_reset !== 1'b1) begin
            $display("FAIL midrst_init: rst=%b want 1", rx_reset);
            n_fail++;
        end
        step();
        n_tests++;
        if (rx_reset !== 1'b0) begin
            $display("FAIL midrst_done: rst=%b want 0", rx_reset);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_speed_switch();
        test_reserved();
        test_forced();
        test_flap_sat();
        test_reset_in_settle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rgmii_link_ctrl.md
# rgmii_link_ctrl

Link/speed controller for the RGMII receive path. It qualifies the in-band status (up, speed, duplex) recovered by the RGMII receiver, or a forced configuration, and decides the active link state. On a speed class change it sequences the receiver: assert its reset, flip its 1000M/10-100M select, hold, release, settle. It sits in the system clock domain between the RGMII receiver and MAC/CSR logic, and publishes link state, a change pulse and a flap counter.

## Interface
- STABLE_CYCLES, 1024: cycles the effective status must be unchanged before it is acted on
- RESET_CYCLES, 16: cycles rx_reset is held during a speed switch and at init
- SETTLE_CYCLES, 64: cycles after rx_reset release before the link is declared up
- clk  in  1  system clock, 125 MHz; one clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_auto  in  1  1 = follow in-band status, 0 = forced mode; quasi-static, clk domain
- cfg_speed  in  2  forced speed: 00 10M, 01 100M, 10 1000M, 11 reserved
- cfg_duplex  in  1  forced duplex, 1 = full
- ibs_up  in  1  in-band link up, asynchronous to clk
- ibs_spd  in  2  in-band speed, same encoding as cfg_speed, asynchronous
- ibs_dplx  in  1  in-band duplex, asynchronous
- rx_speed  out  1  receiver speed select, 1 = 1000M
- rx_reset  out  1  receiver reset, active-high
- link_up  out  1  qualified link state
- link_speed  out  2  qualified speed
- link_duplex  out  1  qualified duplex
- link_chg  out  1  one-cycle pulse on any change of {link_up, link_speed, link_duplex}
- flap_cnt  out  16  saturating count of up-to-down transitions
- flap_clr  in  1  synchronous clear of flap_cnt

## Operation
- ibs_* pass through a 2-flop synchronizer. Multi-bit skew is absorbed by the stability qualification.
- Effective status is eff = cfg_auto ? synced ibs : {1, cfg_speed, cfg_duplex}.
- eff is "valid up" when up = 1 and spd != 11. Reserved speed counts as down.
- INIT, the state after reset: rx_reset = 1 and rx_speed = 1 for RESET_CYCLES, then DOWN.
- DOWN: link_up = 0.
  - eff valid up: capture it as cand, clear cnt, go to QUAL.
- UP:
  - eff differs from {link_up, link_speed, link_duplex}: capture cand, clear cnt, go to QUAL.
- QUAL: link outputs hold their values.
  - eff != cand: cand <= eff, cnt <= 0.
  - eff equals the currently reported status: return to the originating state. This is a glitch filter with no outputs changed.
  - cnt reaches STABLE_CYCLES-1, decide:
    - cand not valid up: go to DOWN. If link_up was 1, pulse link_chg and increment flap_cnt.
    - (cand.spd == 10) != rx_speed: go to SWITCH.
    - otherwise: go to UP, load the link fields from cand, pulse link_chg.
- SWITCH:
  - Entry cycle: rx_reset <= 1, rx_speed <= (cand.spd == 10).
  - If link_up was 1: link_up <= 0, pulse link_chg, increment flap_cnt.
  - Hold RESET_CYCLES, then go to SETTLE.
- SETTLE:
  - rx_reset = 0; eff is ignored.
  - After SETTLE_CYCLES: go to UP, load link fields from cand, pulse link_chg.
  - Any still-pending difference is requalified from UP.
- flap_cnt saturates at 0xFFFF. flap_clr wins over a simultaneous increment, giving 0.
- Changes to cfg_auto or cfg_* follow the same QUAL path; there is no bypass.

## Timing
- Reset values:
  - rx_speed = 1, rx_reset = 1
  - link_up = 0, link_speed = 10, link_duplex = 1
  - link_chg = 0, flap_cnt = 0
  - state INIT
- rst_n assertion mid-operation forces these values immediately and restarts INIT.
- All outputs are registered.
- link_chg is asserted in the same cycle the new link fields first appear.
- Latency from an ibs change to link_chg, same speed class: 2 sync + 1 capture + STABLE_CYCLES cycles.
- With a speed class switch, add RESET_CYCLES + SETTLE_CYCLES.
- rx_speed changes only in the cycle rx_reset rises, never while rx_reset = 0.
- Counter cnt is at least 16 bits. Parameters must be at least 1.

## Structure
- Shared package rgmii_pkg holds:
  - speed codes SPD_10 = 00, SPD_100 = 01, SPD_1000 = 10, SPD_RSVD = 11
  - the state enum: INIT, DOWN, QUAL, SWITCH, SETTLE, UP
- One sub-module, sync_2ff, parameterized width, used for the 4 ibs bits.
- One shared down-counter serves the QUAL, SWITCH and SETTLE phases.

## Test plan
Bench parameters: STABLE_CYCLES = 8, RESET_CYCLES = 4, SETTLE_CYCLES = 6.
- Reset release with ibs = {1, 10, 1}:
  - rx_reset high for 4 cycles, then DOWN → QUAL.
  - link_up = 1, speed 10, duplex 1 with link_chg.
  - rx_speed stays 1 and no SWITCH occurs.
- Up at 1000M, then ibs changes to {1, 01, 1}:
  - link_up falls with link_chg and flap_cnt = 1.
  - rx_speed goes to 0 as rx_reset rises, 4 cycles reset, 6 cycles settle.
  - link_up = 1, speed 01, with a second link_chg.
- Up at 1000M, ibs_up drops for 5 cycles then recovers: no output change and flap_cnt unchanged.
- Up, ibs_spd = 11 held for 20 cycles: link_up = 0 after 2 + 1 + 8 cycles and flap_cnt increments.
- cfg_auto = 0, cfg = {00, 0}, ibs down: link_up = 1, speed 00, duplex 0, rx_speed = 0.
- flap_cnt preloaded to 0xFFFF:
  - A further down transition keeps it at 0xFFFF.
  - flap_clr in the same cycle as a down transition gives 0.
  - rst_n pulse during SETTLE returns all outputs to reset values.
